// File: rtl/execute_pkg.sv
// Shared encodings for the multi-cycle execute stage: instruction class indices,
// ALU sub-ops, jump conditions, status flag positions and FSM states.
package execute_pkg;

    localparam int D_ALU   = 0;
    localparam int D_MUL   = 1;
    localparam int D_DIV   = 2;
    localparam int D_LOAD  = 3;
    localparam int D_STORE = 4;
    localparam int D_JUMP  = 5;
    localparam int D_HALT  = 6;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    localparam logic [2:0] CC_ALWAYS = 3'd0;
    localparam logic [2:0] CC_Z      = 3'd1;
    localparam logic [2:0] CC_NZ     = 3'd2;
    localparam logic [2:0] CC_N      = 3'd3;
    localparam logic [2:0] CC_NN     = 3'd4;
    localparam logic [2:0] CC_C      = 3'd5;
    localparam logic [2:0] CC_V      = 3'd6;
    localparam logic [2:0] CC_NEVER  = 3'd7;

    // status word layout is {Z, N, C, V}
    localparam int S_Z = 3;
    localparam int S_N = 2;
    localparam int S_C = 1;
    localparam int S_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_MEM  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    function automatic logic cc_true(input logic [2:0] cc, input logic [3:0] st);
        logic t;
        case (cc)
            CC_ALWAYS: t = 1'b1;
            CC_Z:      t = st[S_Z];
            CC_NZ:     t = ~st[S_Z];
            CC_N:      t = st[S_N];
            CC_NN:     t = ~st[S_N];
            CC_C:      t = st[S_C];
            CC_V:      t = st[S_V];
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/execute_mc_div_iter.sv
// Unsigned restoring divider core: operand/remainder registers plus one quotient
// bit per step; quo_o is the quotient after the step being taken this cycle.
module div_iter
    import execute_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [WORD-1:0] dividend_i,
    input  logic [WORD-1:0] divisor_i,
    output logic [WORD-1:0] quo_o,
    output logic            dz_o
);

    logic [WORD-1:0] rem_q, quo_q, dsr_q;
    logic [WORD-1:0] rem_d, quo_d;
    logic [WORD:0]   rem_sh, diff;
    logic            ge;

    // Dividend bits shift out of the quotient register into the partial remainder.
    always_comb begin
        rem_sh = {rem_q, quo_q[WORD-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        ge     = (rem_sh >= {1'b0, dsr_q});
        rem_d  = ge ? diff[WORD-1:0] : rem_sh[WORD-1:0];
        quo_d  = {quo_q[WORD-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dsr_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quo_o = quo_d;
    assign dz_o  = (dsr_q == '0);

endmodule

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: single-cycle ALU/MUL/JUMP, iterative DIV, handshaked
// LOAD/STORE and a sticky HALT, with registered writeback and {Z,N,C,V} status.
module execute_mc
    import execute_pkg::*;
#(
    parameter int WORD = 32,
    parameter int ADDR = 16,
    parameter int W_RD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic [WORD-1:0] src_i,
    input  logic [WORD-1:0] dest_i,
    input  logic            wb_i,
    input  logic [W_RD-1:0] wb_rd_name_i,
    input  logic [6:0]      dopc_i,
    input  logic [2:0]      opc_i,
    input  logic [2:0]      cc_i,
    input  logic [ADDR-1:0] origaddr_i,
    output logic            branch_o,
    output logic [ADDR-1:0] baddr_o,
    output logic            wb_o,
    output logic [W_RD-1:0] wb_rd_name_o,
    output logic [WORD-1:0] wb_rd_data_o,
    output logic            dm_req_o,
    output logic            dm_we_o,
    output logic [WORD-1:0] dm_wdata_o,
    input  logic [WORD-1:0] dm_rdata_i,
    input  logic            dm_ack_i,
    output logic            halted_o
);

    localparam int SW = $clog2(WORD);
    localparam logic [SW-1:0] LAST = SW'(WORD - 1);

    // Returns {Z, N, C, V, result}; operand order is dest_i OP src_i.
    function automatic logic [WORD+3:0] arith(input logic mul, input logic [2:0] op,
                                              input logic [WORD-1:0] a, input logic [WORD-1:0] b);
        logic [WORD:0]          s;
        logic [WORD-1:0]        r;
        logic                   c, v;
        logic signed [WORD-1:0] as;
        s  = '0;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        as = a;
        if (mul) begin
            r = a * b;
        end else begin
            case (op)
                OP_ADD: begin
                    s = {1'b0, a} + {1'b0, b};
                    r = s[WORD-1:0];
                    c = s[WORD];
                    v = (a[WORD-1] == b[WORD-1]) && (r[WORD-1] != a[WORD-1]);
                end
                OP_SUB: begin
                    s = {1'b0, a} - {1'b0, b};
                    r = s[WORD-1:0];
                    c = s[WORD];
                    v = (a[WORD-1] != b[WORD-1]) && (r[WORD-1] != a[WORD-1]);
                end
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                OP_SLL:  r = a << b[SW-1:0];
                OP_SRL:  r = a >> b[SW-1:0];
                default: r = as >>> b[SW-1:0];
            endcase
        end
        return {(r == '0), r[WORD-1], c, v, r};
    endfunction

    state_e          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [3:0]      status_q, status_d;
    logic            wb_q, wb_d;
    logic [W_RD-1:0] rd_q, rd_d;
    logic [WORD-1:0] data_q, data_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            store_q, store_d;
    logic            pwb_q, pwb_d;
    logic [W_RD-1:0] prd_q, prd_d;
    logic            div_load, div_step, div_dz;
    logic [WORD-1:0] div_quo;
    logic [WORD+3:0] alu_res;

    assign alu_res = arith(dopc_i[D_MUL], opc_i, dest_i, src_i);

    div_iter #(.WORD(WORD)) u_div (
        .clk        (clk),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (dest_i),
        .divisor_i  (src_i),
        .quo_o      (div_quo),
        .dz_o       (div_dz)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        wb_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        pwb_d    = pwb_q;
        prd_d    = prd_q;
        stall_o  = 1'b0;
        branch_o = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    if (dopc_i[D_ALU] || dopc_i[D_MUL]) begin
                        wb_d     = wb_i;
                        rd_d     = wb_rd_name_i;
                        data_d   = alu_res[WORD-1:0];
                        status_d = alu_res[WORD+3:WORD];
                    end else if (dopc_i[D_JUMP]) begin
                        branch_o = cc_true(cc_i, status_q);
                        status_d = '0;
                    end else if (dopc_i[D_DIV]) begin
                        stall_o  = 1'b1;
                        div_load = 1'b1;
                        cnt_d    = '0;
                        pwb_d    = wb_i;
                        prd_d    = wb_rd_name_i;
                        state_d  = ST_DIV;
                    end else if (dopc_i[D_LOAD] || dopc_i[D_STORE]) begin
                        stall_o  = 1'b1;
                        wdata_d  = dest_i;
                        store_d  = dopc_i[D_STORE];
                        pwb_d    = wb_i & dopc_i[D_LOAD];
                        prd_d    = wb_rd_name_i;
                        state_d  = ST_MEM;
                    end else if (dopc_i[D_HALT]) begin
                        stall_o  = 1'b1;
                        state_d  = ST_HALT;
                    end
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt_q == LAST) begin
                    wb_d     = pwb_q;
                    rd_d     = prd_q;
                    data_d   = div_quo;
                    status_d = {(div_quo == '0), div_quo[WORD-1], 1'b0, div_dz};
                    state_d  = ST_IDLE;
                end else begin
                    stall_o  = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_MEM: begin
                if (dm_ack_i) begin
                    wb_d     = pwb_q;
                    rd_d     = prd_q;
                    data_d   = dm_rdata_i;
                    status_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    stall_o  = 1'b1;
                end
            end
            default: stall_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            status_q <= '0;
            wb_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            pwb_q    <= 1'b0;
            prd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            wb_q     <= wb_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            pwb_q    <= pwb_d;
            prd_q    <= prd_d;
        end
    end

    assign baddr_o      = opc_i[0] ? src_i[ADDR-1:0] : origaddr_i + src_i[ADDR-1:0];
    assign wb_o         = wb_q;
    assign wb_rd_name_o = rd_q;
    assign wb_rd_data_o = data_q;
    assign dm_req_o     = (state_q == ST_MEM);
    assign dm_we_o      = (state_q == ST_MEM) && store_q;
    assign dm_wdata_o   = wdata_q;
    assign halted_o     = (state_q == ST_HALT);

endmodule

// File: tb/tb_execute_mc.sv
// Directed and randomized bench for execute_mc at WORD=8, ADDR=6, checked
// against an arithmetic reference model of results, flags and branch decisions.
module tb_execute_mc;

    localparam int AMASK = 63;

    logic       clk = 1'b0;
    logic       rst, v_i, stall_o, wb_i, branch_o, wb_o;
    logic       dm_req_o, dm_we_o, dm_ack_i, halted_o;
    logic [7:0] src_i, dest_i, wb_rd_data_o, dm_wdata_o, dm_rdata_i;
    logic [3:0] wb_rd_name_i, wb_rd_name_o;
    logic [6:0] dopc_i;
    logic [2:0] opc_i, cc_i;
    logic [5:0] origaddr_i, baddr_o;

    int checks = 0;
    int failures = 0;
    bit mZ, mN, mC, mV;

    execute_mc #(.WORD(8), .ADDR(6), .W_RD(4)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o),
        .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .wb_rd_name_i(wb_rd_name_i),
        .dopc_i(dopc_i), .opc_i(opc_i), .cc_i(cc_i), .origaddr_i(origaddr_i),
        .branch_o(branch_o), .baddr_o(baddr_o), .wb_o(wb_o),
        .wb_rd_name_o(wb_rd_name_o), .wb_rd_data_o(wb_rd_data_o),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_wdata_o(dm_wdata_o),
        .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int to_s8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference result for ALU/MUL with carry and signed-range overflow.
    function automatic int arith(input int cls, input int opc, input int a, input int b,
                                 output bit c, output bit v);
        int s, r;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        if (cls == 1) return (a * b) & 255;
        case (opc)
            0: begin r = (a + b) & 255; c = (a + b) > 255; s = to_s8(a) + to_s8(b); v = (s > 127) || (s < -128); end
            1: begin r = (a - b) & 255; c = a < b;         s = to_s8(a) - to_s8(b); v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a << (b & 7)) & 255;
            6: r = a >> (b & 7);
            default: r = (to_s8(a) >>> (b & 7)) & 255;
        endcase
        return r;
    endfunction

    function automatic bit cond(input int cc);
        case (cc)
            0: return 1'b1;
            1: return mZ;
            2: return !mZ;
            3: return mN;
            4: return !mN;
            5: return mC;
            6: return mV;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_flags(input int r, input bit c, input bit v);
        mZ = (r == 0);
        mN = (r >= 128);
        mC = c;
        mV = v;
    endtask

    // Issue one instruction at posedge+1 and follow it to completion.
    task automatic run_op(input int cls, input int opc, input int cc, input int src, input int dst,
                          input bit wbf, input int rd, input int orig, input int lat, input int rdata);
        int r, stl, ba;
        bit c, v, br;
        v_i = 1'b1; dopc_i = 7'(1 << cls); opc_i = 3'(opc); cc_i = 3'(cc);
        src_i = 8'(src); dest_i = 8'(dst); wb_i = wbf; wb_rd_name_i = 4'(rd); origaddr_i = 6'(orig);
        dm_ack_i = (cls <= 1 || cls == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (cls <= 1) begin
            r = arith(cls, opc, dst, src, c, v);
            chk("alu_stall", 32'(stall_o), 0);
            tick;
            chk("alu_wb", 32'(wb_o), 32'(wbf));
            if (wbf) begin
                chk("alu_data", 32'(wb_rd_data_o), r);
                chk("alu_rd", 32'(wb_rd_name_o), rd);
            end
            set_flags(r, c, v);
        end else if (cls == 5) begin
            br = cond(cc);
            ba = (opc & 1) ? (src & AMASK) : ((orig + (src & AMASK)) & AMASK);
            chk("jump_branch", 32'(branch_o), 32'(br));
            chk("jump_baddr", 32'(baddr_o), ba);
            chk("jump_stall", 32'(stall_o), 0);
            tick;
            chk("jump_wb", 32'(wb_o), 0);
            set_flags(1, 1'b0, 1'b0);
        end else if (cls == 2) begin
            stl = 0;
            while (stall_o === 1'b1 && stl < 40) begin
                stl++;
                @(posedge clk);
                #1;
                if (stl == 2) chk("div_wb_busy", 32'(wb_o), 0);
            end
            chk("div_stall_cycles", stl, 8);
            tick;
            r = (src == 0) ? 255 : dst / src;
            chk("div_wb", 32'(wb_o), 32'(wbf));
            if (wbf) chk("div_data", 32'(wb_rd_data_o), r);
            set_flags(r, 1'b0, src == 0);
        end else begin
            chk("mem_accept_stall", 32'(stall_o), 1);
            chk("mem_accept_req", 32'(dm_req_o), 0);
            tick;
            for (int k = 1; k <= lat; k++) begin
                chk("mem_req", 32'(dm_req_o), 1);
                chk("mem_we", 32'(dm_we_o), 32'(cls == 4));
                chk("mem_wdata", 32'(dm_wdata_o), dst);
                if (k == lat) begin
                    dm_ack_i = 1'b1;
                    dm_rdata_i = 8'(rdata);
                    #1;
                    chk("mem_done_stall", 32'(stall_o), 0);
                end else begin
                    chk("mem_wait_stall", 32'(stall_o), 1);
                end
                tick;
            end
            dm_ack_i = 1'b0;
            chk("mem_wb", 32'(wb_o), 32'(cls == 3 && wbf));
            if (cls == 3 && wbf) chk("mem_data", 32'(wb_rd_data_o), rdata);
            chk("mem_req_after", 32'(dm_req_o), 0);
            set_flags(1, 1'b0, 1'b0);
        end
        dm_ack_i = 1'b0;
        v_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v_i = 1'b0; src_i = '0; dest_i = '0; wb_i = 1'b0; wb_rd_name_i = '0;
        dopc_i = '0; opc_i = '0; cc_i = '0; origaddr_i = '0; dm_rdata_i = '0; dm_ack_i = 1'b0;
        mZ = 0; mN = 0; mC = 0; mV = 0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_wb", 32'(wb_o), 0);
        chk("rst_halted", 32'(halted_o), 0);
        chk("rst_dm_req", 32'(dm_req_o), 0);
        chk("rst_wb_data", 32'(wb_rd_data_o), 0);
        chk("rst_branch", 32'(branch_o), 0);
        tick;

        // Cleared status: Z condition not taken; relative jump wraps mod 2^ADDR.
        run_op(5, 0, 1, 8'h0A, 0, 0, 0, 60, 0, 0);
        run_op(5, 0, 0, 8'h0A, 0, 0, 0, 60, 0, 0);
        run_op(5, 1, 0, 8'hD7, 0, 0, 0, 12, 0, 0);

        // 0x7F + 1 overflows into the sign bit; V-conditioned jump then taken.
        run_op(0, 0, 0, 8'h01, 8'h7F, 1, 3, 0, 0, 0);
        chk("add_overflow_data", 32'(wb_rd_data_o), 32'h80);
        run_op(5, 0, 6, 8'h04, 0, 0, 0, 20, 0, 0);
        tick;
        chk("bubble_wb", 32'(wb_o), 0);

        run_op(2, 0, 0, 7, 200, 1, 5, 0, 0, 0);
        chk("div_200_7", 32'(wb_rd_data_o), 28);
        run_op(2, 0, 0, 0, 5, 1, 6, 0, 0, 0);
        chk("div_by_zero", 32'(wb_rd_data_o), 32'hFF);
        run_op(5, 0, 6, 8'h01, 0, 0, 0, 2, 0, 0);

        run_op(3, 0, 0, 0, 0, 1, 7, 0, 3, 8'hA5);
        run_op(4, 0, 0, 0, 8'h3C, 1, 8, 0, 1, 0);
        run_op(5, 0, 2, 8'h01, 0, 0, 0, 2, 0, 0);
        run_op(0, 1, 0, 8'h01, 8'h00, 1, 9, 0, 0, 0);
        run_op(5, 0, 5, 8'h01, 0, 0, 0, 2, 0, 0);
        run_op(1, 0, 0, 8'h13, 8'h11, 1, 2, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                dm_ack_i = 1'($urandom_range(0, 1));
                tick;
                chk("rand_bubble_wb", 32'(wb_o), 0);
                chk("rand_bubble_req", 32'(dm_req_o), 0);
                dm_ack_i = 1'b0;
            end
            run_op($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(1, 4),
                   $urandom_range(0, 255));
        end

        // Reset in the middle of a divide.
        v_i = 1'b1; dopc_i = 7'(1 << 2); src_i = 8'd3; dest_i = 8'd90; wb_i = 1'b1;
        tick;
        tick;
        tick;
        rst = 1'b1; v_i = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        set_flags(1, 1'b0, 1'b0);
        chk("rst_div_stall", 32'(stall_o), 0);
        chk("rst_div_wb", 32'(wb_o), 0);
        tick;
        chk("rst_div_wb_later", 32'(wb_o), 0);
        run_op(0, 0, 0, 8'h22, 8'h11, 1, 4, 0, 0, 0);
        chk("post_rst_add", 32'(wb_rd_data_o), 32'h33);

        // Reset in the middle of a load.
        v_i = 1'b1; dopc_i = 7'(1 << 3); wb_i = 1'b1; dm_ack_i = 1'b0;
        tick;
        rst = 1'b1; v_i = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        set_flags(1, 1'b0, 1'b0);
        chk("rst_mem_req", 32'(dm_req_o), 0);
        chk("rst_mem_wb", 32'(wb_o), 0);
        run_op(5, 0, 6, 8'h01, 0, 0, 0, 2, 0, 0);

        // HALT is sticky until reset.
        v_i = 1'b1; dopc_i = 7'(1 << 6);
        #1;
        chk("halt_accept_stall", 32'(stall_o), 1);
        tick;
        for (int k = 0; k < 4; k++) begin
            v_i = 1'b1; dopc_i = (k % 2 == 1) ? 7'(1 << 5) : 7'(1 << 0); cc_i = 3'd0; wb_i = 1'b1;
            #1;
            chk("halt_stall", 32'(stall_o), 1);
            chk("halt_halted", 32'(halted_o), 1);
            chk("halt_branch", 32'(branch_o), 0);
            tick;
            chk("halt_wb", 32'(wb_o), 0);
        end
        rst = 1'b1; v_i = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted_o), 0);
        chk("halt_rst_stall", 32'(stall_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter WORD, 32, datapath width (≥4).
REQ-002 Parameter ADDR, 16, instruction address width (≤WORD).
REQ-003 Parameter W_RD, 4, register-name width.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  one clock; reset is synchronous and active-high.
REQ-006 v_i  input  1  valid instruction from ID.
REQ-007 stall_o  output  1  ID holds all inputs stable while high.
REQ-008 src_i, dest_i  input  WORD  operands; dest_i is store data.
REQ-009 wb_i  input  1  instruction writes a register; wb_rd_name_i  input  W_RD  target.
REQ-010 dopc_i  input  7  one-hot class {ALU, MUL, DIV, LOAD, STORE, JUMP, HALT}.
REQ-011 opc_i  input  3  ALU sub-op {ADD, SUB, AND, OR, XOR, SLL, SRL, SRA}; JUMP: bit0=1 absolute.
REQ-012 cc_i  input  3  jump condition; origaddr_i  input  ADDR  address of this instruction.
REQ-013 branch_o  output  1 taken; baddr_o  output  ADDR  target.
REQ-014 wb_o  output  1; wb_rd_name_o  output  W_RD; wb_rd_data_o  output  WORD  registered writeback.
REQ-015 dm_req_o, dm_we_o  output  1; dm_wdata_o  output  WORD; dm_rdata_i  input  WORD; dm_ack_i  input  1 (address driven by ID).
REQ-016 halted_o  output  1  core halted.

Function
REQ-017 FSM states IDLE, DIV, MEM, HALT; all instruction acceptance occurs in IDLE with v_i=1.
REQ-018 ALU, MUL, JUMP complete in the accepting cycle; wb_o = wb_i & ALU|MUL at the next edge; stall_o low.
REQ-019 ALU: ADD/SUB modulo 2^WORD with C carry/borrow-out, V signed overflow; shifts use src_i[log2(WORD)-1:0]; logic/shift C=V=0.
REQ-020 MUL: low WORD bits of unsigned product, C=V=0; Z, N from result for all arithmetic classes.
REQ-021 DIV: unsigned restoring, one quotient bit per cycle; accept cycle IDLE→DIV count=0; DIV ends at count=WORD-1, stall_o low in that cycle, quotient written at that edge; stall_o high for exactly WORD cycles.
REQ-022 DIV by zero: quotient all ones, V=1.
REQ-023 LOAD/STORE: accept IDLE→MEM; dm_req_o high throughout MEM, dm_we_o=STORE, dm_wdata_o=dest_i captured at accept; completion on dm_ack_i in MEM, stall_o low that cycle, →IDLE.
REQ-024 LOAD writes dm_rdata_i sampled with dm_ack_i; STORE never asserts wb_o; dm_ack_i outside MEM ignored.
REQ-025 stall_o = (IDLE & v_i & DIV|LOAD|STORE|HALT) | (DIV & not last) | (MEM & ~dm_ack_i) | HALT.
REQ-026 branch_o combinational = IDLE & v_i & JUMP & cond; cc: 0 always, 1 Z, 2 ~Z, 3 N, 4 ~N, 5 C, 6 V, 7 never, tested against status_r.
REQ-027 baddr_o = src_i[ADDR-1:0] if absolute else origaddr_i + src_i[ADDR-1:0], wrapping mod 2^ADDR.
REQ-028 status_r {Z,N,C,V} updated at completion: arithmetic flags for ALU/MUL/DIV, cleared for LOAD/STORE/JUMP; held on bubbles (v_i=0).
REQ-029 HALT: enter HALT state, stall_o and halted_o high until rst; no further writeback.
REQ-030 wb_o is low in every cycle following a bubble or non-completing cycle.

Reset
REQ-031 rst: state IDLE, status_r=0, count=0, all registered outputs 0, dm_req_o=0, halted_o=0.
REQ-032 rst during DIV/MEM aborts the operation: no writeback, dm_req_o low from the next cycle.

Structure
REQ-033 Package execute_pkg holds dopc indices, opc codes, cc codes, status bit indices, FSM state encoding.
REQ-034 Sub-module div_iter (WORD-parameterised restoring step and operand/remainder registers); all other logic flat.

Verification
REQ-035 WORD=8: ADD 0x7F+0x01 → wb data 0x80, N=1 V=1 C=0; next JUMP cc=6 → branch_o=1.
REQ-036 WORD=8: DIV 200/7 → stall_o high 8 cycles, wb data 28 one cycle later; DIV 5/0 → 0xFF, V=1.
REQ-037 LOAD with dm_ack_i after 3 cycles, rdata 0xA5 → one wb of 0xA5, dm_req_o high 3 cycles then low.
REQ-038 STORE dest_i=0x3C, ack at cycle 1 → dm_we_o=1, dm_wdata_o=0x3C, wb_o never high, status_r cleared.
REQ-039 rst asserted mid-DIV → next cycle stall_o=0, wb_o=0; following ADD completes normally.
REQ-040 HALT then further v_i → stall_o, halted_o stay 1, no wb_o, branch_o=0 until rst.
